// File: rtl/count_seq_checker.sv
// Sequence monitor for an up-counter: locks onto a +1 (mod 2^WIDTH) count stream,
// then flags and counts sequence faults and max->0 wraps. All outputs registered.
module count_seq_checker #(
    parameter int WIDTH       = 4,
    parameter int LOCK_CYCLES = 2,
    parameter int ERR_W       = 8,
    parameter int WRAP_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              en,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    // LOCK_CYCLES <= 15, so a 4-bit run counter never overflows before lock
    localparam logic [3:0]        LOCK_N   = LOCK_CYCLES[3:0];
    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    logic [1:0]       state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       good;
    logic [WIDTH-1:0] exp_cnt;
    logic             match;

    assign exp_cnt = prev + WIDTH'(1);
    assign match   = (count_in == exp_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev       <= '0;
            good       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
        end else if (clear) begin
            state      <= IDLE;
            prev       <= '0;
            good       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (en) begin
                prev <= count_in;
                case (state)
                    IDLE: begin
                        good  <= '0;
                        state <= SYNC;
                    end
                    SYNC: begin
                        if (!match) begin
                            good <= '0;
                        end else if (good + 4'd1 == LOCK_N) begin
                            good   <= '0;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good <= good + 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            // a max->0 step is a legal increment, counted as a wrap
                            if (prev == CNT_MAX) begin
                                wrap_pulse <= 1'b1;
                                wrap_cnt   <= wrap_cnt + WRAP_W'(1);
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_cnt != ERR_MAX)
                                err_cnt <= err_cnt + ERR_W'(1);
                            good   <= '0;
                            state  <= SYNC;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        good   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
